// File: rtl/power_channel_ramp_if.sv
// Front-panel / measurement bundle for one power-supply channel.
//   master : encoder phases, channel enable and measured current out; setpoints,
//            mode, ramp status and output command in.
//   slave  : the channel controller side (power_channel_ramp).
// Signals
//   v_enc_a/b  voltage encoder quadrature phases (asynchronous)
//   i_enc_a/b  current encoder quadrature phases (asynchronous)
//   powered    channel enable
//   i_meas     measured output current
//   mode       0 = CV, 1 = CC
//   v_set      voltage setpoint
//   i_set      current setpoint
//   value_out  slew-limited output command for the DAC
//   ramping    1 while value_out has not yet reached its target
interface power_channel_ramp_if #(
   parameter int WIDTH = 18
);
   logic             v_enc_a;
   logic             v_enc_b;
   logic             i_enc_a;
   logic             i_enc_b;
   logic             powered;
   logic [WIDTH-1:0] i_meas;
   logic             mode;
   logic [WIDTH-1:0] v_set;
   logic [WIDTH-1:0] i_set;
   logic [WIDTH-1:0] value_out;
   logic             ramping;

   modport master (
      output v_enc_a, v_enc_b, i_enc_a, i_enc_b, powered, i_meas,
      input  mode, v_set, i_set, value_out, ramping
   );

   modport slave (
      input  v_enc_a, v_enc_b, i_enc_a, i_enc_b, powered, i_meas,
      output mode, v_set, i_set, value_out, ramping
   );
endinterface

// File: rtl/power_channel_ramp.sv
// Power-supply channel controller. Two quadrature encoders set the voltage and
// current setpoints, CV/CC mode is chosen from the measured current, and the
// DAC command value_out slews toward the active setpoint by at most RAMP_STEP
// per control tick. Control ticks come from a CLK_DIV clock divider.
// Ports
//   clk    system clock, everything on posedge
//   rst_n  synchronous active-low reset
//   bus    power_channel_ramp_if.slave: encoder phases, powered, i_meas in;
//          mode, v_set, i_set, value_out, ramping out
module power_channel_ramp #(
   parameter int WIDTH     = 18,
   parameter int CLK_DIV   = 5000,
   parameter int V_MAX     = 2**18-1,
   parameter int I_MAX     = 2**18-1,
   parameter int STEP      = 1,
   parameter int RAMP_STEP = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   power_channel_ramp_if.slave   bus
);

   localparam int                      CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [WIDTH:0]          V_LIM  = (WIDTH+1)'(V_MAX);
   localparam logic [WIDTH:0]          I_LIM  = (WIDTH+1)'(I_MAX);
   localparam logic [WIDTH:0]          STEP_W = (WIDTH+1)'(STEP);
   localparam logic signed [WIDTH+1:0] RAMP_S = (WIDTH+2)'(RAMP_STEP);
   localparam logic [WIDTH-1:0]        RAMP_U = WIDTH'(RAMP_STEP);

   // Position of a phase pair {a,b} along the clockwise cycle 00,01,11,10.
   function automatic logic [1:0] gray_pos(input logic [1:0] code);
      logic [1:0] pos;
      case (code)
         2'b00:   pos = 2'd0;
         2'b01:   pos = 2'd1;
         2'b11:   pos = 2'd2;
         default: pos = 2'd3;
      endcase
      return pos;
   endfunction

   // Modulo-4 position difference: 1 = clockwise, 3 = counter-clockwise,
   // 0 = no movement, 2 = both phases changed (invalid, ignored).
   function automatic logic [1:0] enc_dir(input logic [1:0] prev, input logic [1:0] curr);
      return gray_pos(curr) - gray_pos(prev);
   endfunction

   // Setpoint step with saturation at 0 and lim; one guard bit keeps the
   // increment from wrapping before it is compared with the limit.
   function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] val,
                                                 input logic [1:0]       dir,
                                                 input logic [WIDTH:0]   lim);
      logic [WIDTH:0] wide;
      wide = {1'b0, val};
      case (dir)
         2'd1: begin
            wide = wide + STEP_W;
            if (wide > lim) wide = lim;
         end
         2'd3:    wide = (wide < STEP_W) ? '0 : wide - STEP_W;
         default: wide = {1'b0, val};
      endcase
      return wide[WIDTH-1:0];
   endfunction

   // Slew limiter: signed distance to target decides between landing on the
   // target and moving a full RAMP_STEP, so it never overshoots or underflows.
   function automatic logic [WIDTH-1:0] ramp_next(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] tgt);
      logic signed [WIDTH+1:0] diff;
      diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
      if (diff > RAMP_S)       return cur + RAMP_U;
      else if (diff < -RAMP_S) return cur - RAMP_U;
      else                     return tgt;
   endfunction

   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic [1:0]       v_enc_p0, v_enc_p1;
   logic [1:0]       i_enc_p0, i_enc_p1;
   logic [1:0]       v_hist, i_hist;
   logic             hist_vld;
   logic [WIDTH-1:0] v_set_r, i_set_r, value_r, target;
   logic             mode_r, ramping_r;

   assign tick = (cnt == CNT_LAST);

   // Stage p0/p1: two-flop synchronisers for the asynchronous encoder phases.
   always_ff @(posedge clk) begin
      v_enc_p0 <= {bus.v_enc_a, bus.v_enc_b};
      i_enc_p0 <= {bus.i_enc_a, bus.i_enc_b};
      v_enc_p1 <= v_enc_p0;
      i_enc_p1 <= i_enc_p0;
   end

   // Target from registered mode/setpoints; an unpowered channel aims at 0.
   always_comb begin
      target = '0;
      if (bus.powered) target = mode_r ? i_set_r : v_set_r;
   end

   // Control state: divider, encoder history, setpoints, mode and slew output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         hist_vld  <= 1'b0;
         v_hist    <= '0;
         i_hist    <= '0;
         v_set_r   <= '0;
         i_set_r   <= '0;
         mode_r    <= 1'b0;
         value_r   <= '0;
         ramping_r <= 1'b0;
      end else begin
         cnt       <= tick ? '0 : cnt + CNT_W'(1);
         ramping_r <= (value_r != target);
         // Power-off clears the command immediately, not on a tick.
         if (!bus.powered)  value_r <= '0;
         else if (tick)     value_r <= ramp_next(value_r, target);
         if (tick) begin
            // Compares against i_set before this tick's encoder update.
            mode_r   <= bus.powered & (bus.i_meas >= i_set_r);
            v_hist   <= v_enc_p1;
            i_hist   <= i_enc_p1;
            hist_vld <= 1'b1;
            // First tick after reset only primes the history.
            if (hist_vld) begin
               v_set_r <= sat_step(v_set_r, enc_dir(v_hist, v_enc_p1), V_LIM);
               i_set_r <= sat_step(i_set_r, enc_dir(i_hist, i_enc_p1), I_LIM);
            end
         end
      end
   end

   assign bus.mode      = mode_r;
   assign bus.v_set     = v_set_r;
   assign bus.i_set     = i_set_r;
   assign bus.value_out = value_r;
   assign bus.ramping   = ramping_r;

endmodule

// File: tb/tb_power_channel_ramp.sv
// Bench for power_channel_ramp: two instances (full-range clamps and small
// V_MAX/I_MAX clamps) share one stimulus stream; a behavioural model is
// compared with both on every falling edge, and directed scenarios pin the
// model with hand-computed values.
module tb_power_channel_ramp;

   localparam int W   = 18;
   localparam int CD  = 4;
   localparam int RS  = 16;
   localparam int ST  = 1;
   localparam int VM0 = 2**18-1;
   localparam int IM0 = 2**18-1;
   localparam int VM1 = 10;
   localparam int IM1 = 12;

   logic         clk;
   logic         rst_n;
   logic [1:0]   vc, ic;
   logic         pw;
   logic [W-1:0] im;

   power_channel_ramp_if #(.WIDTH(W)) bus0 ();
   power_channel_ramp_if #(.WIDTH(W)) bus1 ();

   assign bus0.v_enc_a = vc[1];
   assign bus0.v_enc_b = vc[0];
   assign bus0.i_enc_a = ic[1];
   assign bus0.i_enc_b = ic[0];
   assign bus0.powered = pw;
   assign bus0.i_meas  = im;
   assign bus1.v_enc_a = vc[1];
   assign bus1.v_enc_b = vc[0];
   assign bus1.i_enc_a = ic[1];
   assign bus1.i_enc_b = ic[0];
   assign bus1.powered = pw;
   assign bus1.i_meas  = im;

   power_channel_ramp #(.WIDTH(W), .CLK_DIV(CD), .V_MAX(VM0), .I_MAX(IM0),
                        .STEP(ST), .RAMP_STEP(RS))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   power_channel_ramp #(.WIDTH(W), .CLK_DIV(CD), .V_MAX(VM1), .I_MAX(IM1),
                        .STEP(ST), .RAMP_STEP(RS))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   logic [W-1:0] o_v[2], o_i[2], o_val[2];
   logic         o_mode[2], o_ramp[2];
   assign o_v[0] = bus0.v_set;      assign o_v[1] = bus1.v_set;
   assign o_i[0] = bus0.i_set;      assign o_i[1] = bus1.i_set;
   assign o_val[0] = bus0.value_out; assign o_val[1] = bus1.value_out;
   assign o_mode[0] = bus0.mode;    assign o_mode[1] = bus1.mode;
   assign o_ramp[0] = bus0.ramping; assign o_ramp[1] = bus1.ramping;

   int n_vec = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [1:0] cw(input logic [1:0] c);
      case (c)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] ccw(input logic [1:0] c);
      case (c)
         2'b01:   return 2'b00;
         2'b11:   return 2'b01;
         2'b10:   return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int gray_dir(input logic [1:0] o, input logic [1:0] n);
      if (n == o)     return 0;
      if (n == cw(o)) return 1;
      if (o == cw(n)) return -1;
      return 0;
   endfunction

   function automatic int clampi(input int x, input int hi);
      if (x < 0)  return 0;
      if (x > hi) return hi;
      return x;
   endfunction

   function automatic int ramp(input int c, input int t);
      if (t - c > RS) return c + RS;
      if (c - t > RS) return c - RS;
      return t;
   endfunction

   int         vmax_a[2] = '{VM0, VM1};
   int         imax_a[2] = '{IM0, IM1};
   int         mv[2], mi[2], mval[2];
   bit         mmode[2], mramp[2];
   int         mcnt;
   bit         mhv, m_tick, started;
   logic [1:0] mhist_v, mhist_i;
   logic [1:0] dv1 = 2'b00, dv2 = 2'b00, di1 = 2'b00, di2 = 2'b00;

   // Encoder phases become visible to the tick logic two clocks after they are
   // driven (synchroniser latency); everything else follows the tick rules.
   task automatic model_step();
      logic [1:0] sv, si;
      bit tk;
      int tgt;
      sv = dv2; si = di2;
      dv2 = dv1; dv1 = vc; di2 = di1; di1 = ic;
      if (!rst_n) begin
         started = 1'b1;
         mcnt = 0; mhv = 1'b0; m_tick = 1'b0;
         for (int d = 0; d < 2; d++) begin
            mv[d] = 0; mi[d] = 0; mval[d] = 0; mmode[d] = 1'b0; mramp[d] = 1'b0;
         end
      end else begin
         tk = (mcnt == CD - 1);
         mcnt = tk ? 0 : mcnt + 1;
         m_tick = tk;
         for (int d = 0; d < 2; d++) begin
            tgt = !pw ? 0 : (mmode[d] ? mi[d] : mv[d]);
            mramp[d] = (mval[d] != tgt);
            if (!pw)     mval[d] = 0;
            else if (tk) mval[d] = ramp(mval[d], tgt);
            if (tk) begin
               mmode[d] = pw && (int'(im) >= mi[d]);
               if (mhv) begin
                  mv[d] = clampi(mv[d] + gray_dir(mhist_v, sv) * ST, vmax_a[d]);
                  mi[d] = clampi(mi[d] + gray_dir(mhist_i, si) * ST, imax_a[d]);
               end
            end
         end
         if (tk) begin
            mhist_v = sv; mhist_i = si; mhv = 1'b1;
         end
      end
   endtask

   initial begin
      started = 1'b0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Every-cycle comparison of both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("dut%0d v_set", d),     32'(o_v[d]),    32'(mv[d]));
               chk($sformatf("dut%0d i_set", d),     32'(o_i[d]),    32'(mi[d]));
               chk($sformatf("dut%0d value_out", d), 32'(o_val[d]),  32'(mval[d]));
               chk($sformatf("dut%0d mode", d),      32'(o_mode[d]), 32'(mmode[d]));
               chk($sformatf("dut%0d ramping", d),   32'(o_ramp[d]), 32'(mramp[d]));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected $finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_tick && n < 4 * CD);
      if (!m_tick) begin
         n_vec++;
         n_bad++;
         $display("FAIL tick_wait: no tick after %0d cycles, expected one within %0d", n, CD);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [1:0] rand_move(input logic [1:0] c);
      case ($urandom_range(0, 4))
         2:       return cw(c);
         3:       return ccw(c);
         4:       return ~c;
         default: return c;
      endcase
   endfunction

   initial begin
      rst_n = 1'b1; pw = 1'b0; im = '0; vc = 2'b00; ic = 2'b00;
      @(negedge clk);

      // Reset held three cycles: everything reads 0.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst value_out", 32'(o_val[0]), 0);
      chk("rst v_set",     32'(o_v[0]),   0);
      chk("rst i_set",     32'(o_i[0]),   0);
      chk("rst mode",      32'(o_mode[0]), 0);
      chk("rst ramping",   32'(o_ramp[0]), 0);
      rst_n = 1'b1;
      repeat (10) wait_tick();
      chk("static v_set", 32'(o_v[0]), 0);
      chk("static i_set", 32'(o_i[0]), 0);

      // Current encoder up first so i_meas=0 stays below i_set (CV mode).
      pw = 1'b1; im = '0;
      repeat (30) begin wait_tick(); ic = cw(ic); end
      repeat (20) begin wait_tick(); vc = cw(vc); end
      repeat (4) wait_tick();
      chk("cw20 v_set",      32'(o_v[0]),    20);
      chk("cw20 mode",       32'(o_mode[0]), 0);
      chk("cw20 value_out",  32'(o_val[0]),  20);
      chk("cw20 ramping",    32'(o_ramp[0]), 0);
      chk("cw30 i_set",      32'(o_i[0]),    30);
      chk("vmax10 v_set",    32'(o_v[1]),    10);
      chk("imax12 i_set",    32'(o_i[1]),    12);

      // Invalid 00 -> 11 jump is ignored.
      wait_tick();
      vc = 2'b11;
      repeat (3) wait_tick();
      chk("invalid v_set",   32'(o_v[0]), 20);
      chk("invalid v_set10", 32'(o_v[1]), 10);

      // 25 counter-clockwise steps clamp at 0.
      repeat (25) begin wait_tick(); vc = ccw(vc); end
      repeat (3) wait_tick();
      chk("ccw25 v_set",  32'(o_v[0]), 0);
      chk("ccw25 v_set1", 32'(o_v[1]), 0);

      // v_set=100, i_set=5, then i_meas=5 forces CC and ramps down to 5.
      do_reset(2);
      pw = 1'b1; im = '0;
      for (int n = 0; n < 100; n++) begin
         wait_tick();
         vc = cw(vc);
         if (n < 5) ic = cw(ic);
      end
      repeat (8) wait_tick();
      chk("cv100 value_out", 32'(o_val[0]),  100);
      chk("cv100 mode",      32'(o_mode[0]), 0);
      im = W'(5);
      repeat (10) wait_tick();
      chk("cc mode",        32'(o_mode[0]), 1);
      chk("cc value_out",   32'(o_val[0]),  5);
      chk("cc value_out1",  32'(o_val[1]),  5);

      // Back to CV at 100, drop power, then ramp up from 0.
      im = '0;
      repeat (10) wait_tick();
      chk("cv back value_out", 32'(o_val[0]), 100);
      pw = 1'b0;
      @(negedge clk);
      chk("poweroff value_out",  32'(o_val[0]), 0);
      chk("poweroff value_out1", 32'(o_val[1]), 0);
      repeat (2) wait_tick();
      pw = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         wait_tick();
         chk($sformatf("rampup tick%0d", k), 32'(o_val[0]), (16 * k > 100) ? 100 : 16 * k);
      end
      chk("rampup value_out1", 32'(o_val[1]), 10);

      // Randomised encoder/power/current activity with occasional resets.
      for (int t = 0; t < 300; t++) begin
         wait_tick();
         if ($urandom_range(0, 99) < 1) begin
            do_reset(2);
         end else begin
            if ($urandom_range(0, 99) < 6) pw = ~pw;
            vc = rand_move(vc);
            ic = rand_move(ic);
            case ($urandom_range(0, 3))
               0:       im = '0;
               1:       im = W'(mi[0]);
               2:       im = W'(mi[0] + 1);
               default: im = W'($urandom_range(0, 40));
            endcase
         end
      end

      // Both encoders clockwise together eight times.
      do_reset(2);
      wait_tick();
      repeat (8) begin wait_tick(); vc = cw(vc); ic = cw(ic); end
      repeat (3) wait_tick();
      chk("both v_set",  32'(o_v[0]), 8);
      chk("both i_set",  32'(o_i[0]), 8);
      chk("both v_set1", 32'(o_v[1]), 8);
      chk("both i_set1", 32'(o_i[1]), 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
